// File: rtl/bcd_seg_pkg.sv
// rtl/bcd_seg_pkg.sv - shared segment/digit constants for the BCD scanning display
// Purpose: active-low 7-segment patterns {dp,g,f,e,d,c,b,a} and digit-enable codes.
// Ports: none (package).
package bcd_seg_pkg;
   localparam logic [7:0] SEG_0    = 8'hC0;
   localparam logic [7:0] SEG_1    = 8'hF9;
   localparam logic [7:0] SEG_2    = 8'hA4;
   localparam logic [7:0] SEG_3    = 8'hB0;
   localparam logic [7:0] SEG_4    = 8'h99;
   localparam logic [7:0] SEG_5    = 8'h92;
   localparam logic [7:0] SEG_6    = 8'h82;
   localparam logic [7:0] SEG_7    = 8'hF8;
   localparam logic [7:0] SEG_8    = 8'h80;
   localparam logic [7:0] SEG_9    = 8'h90;
   localparam logic [7:0] SEG_DASH = 8'hBF;
   localparam logic [7:0] SEG_OFF  = 8'hFF;

   localparam logic [1:0] DIG_OFF  = 2'b11;
   localparam logic [1:0] DIG_ONES = 2'b10;
   localparam logic [1:0] DIG_TENS = 2'b01;
endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD to active-low 7-segment decoder
// Purpose: maps one BCD digit to its segment pattern; non-BCD codes 10..15 show a dash.
// Ports:
//   bcd  in   4  BCD digit
//   seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}, dp always off
module bcd_to_seg7
   import bcd_seg_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_seg_scan.sv
// rtl/bcd_seg_scan.sv - double-buffered 2-digit multiplexed 7-segment driver
// Purpose: captures a tens/ones BCD pair into a pending buffer, copies it to the display
//   register only at frame boundaries, and scans it onto a common-anode display with a
//   blank window at the start of every digit slot to suppress ghosting.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank the tens digit when it is 0.
// Ports:
//   clk       in   1  system clock
//   rst       in   1  synchronous, active-high reset
//   in_valid  in   1  one-cycle strobe capturing in_tens/in_ones into the pending buffer
//   in_tens   in   4  BCD tens digit
//   in_ones   in   4  BCD ones digit
//   seg_n     out  8  active-low segments {dp,g,f,e,d,c,b,a}, registered
//   dig_n     out  2  active-low digit enables, [0]=ones [1]=tens, registered
//   upd_ack   out  1  one-cycle pulse after pending data is copied to the display register
module bcd_seg_scan
   import bcd_seg_pkg::*;
#(
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [3:0] in_tens,
   input  logic [3:0] in_ones,
   output logic [7:0] seg_n,
   output logic [1:0] dig_n,
   output logic       upd_ack
);

   localparam int CW = $clog2(CLK_DIV);

   logic [CW-1:0] div_cnt;
   logic          idx;        // 0 = ones slot, 1 = tens slot
   logic [3:0]    pend_tens;
   logic [3:0]    pend_ones;
   logic          pend_flag;
   logic [3:0]    disp_tens;
   logic [3:0]    disp_ones;

   logic          tick;
   logic          frame_end;
   logic          blank;
   logic [3:0]    cur_digit;
   logic [7:0]    dec_seg;
   logic [7:0]    seg_next;

   assign tick      = (div_cnt == CW'(CLK_DIV - 1));
   assign frame_end = tick && idx;
   assign blank     = (div_cnt < CW'(BLANK_CYCLES));
   assign cur_digit = idx ? disp_tens : disp_ones;

   bcd_to_seg7 u_dec (
      .bcd (cur_digit),
      .seg (dec_seg)
   );

`ifdef LEADING_ZERO_BLANK_EN
   // Tens slot still gets its digit enable; only the segments go dark.
   assign seg_next = (idx && (disp_tens == 4'd0)) ? SEG_OFF : dec_seg;
`else
   assign seg_next = dec_seg;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt   <= '0;
         idx       <= 1'b0;
         pend_tens <= 4'd0;
         pend_ones <= 4'd0;
         pend_flag <= 1'b0;
         disp_tens <= 4'd0;
         disp_ones <= 4'd0;
         seg_n     <= SEG_OFF;
         dig_n     <= DIG_OFF;
         upd_ack   <= 1'b0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + CW'(1);
         if (tick)
            idx <= ~idx;

         upd_ack <= 1'b0;
         if (frame_end && pend_flag) begin
            disp_tens <= pend_tens;
            disp_ones <= pend_ones;
            pend_flag <= 1'b0;
            upd_ack   <= 1'b1;
         end

         // Placed after the copy so a strobe on the boundary cycle re-arms pend_flag
         // and its data waits for the following frame.
         if (in_valid) begin
            pend_tens <= in_tens;
            pend_ones <= in_ones;
            pend_flag <= 1'b1;
         end

         if (blank) begin
            seg_n <= SEG_OFF;
            dig_n <= DIG_OFF;
         end else begin
            seg_n <= seg_next;
            dig_n <= idx ? DIG_TENS : DIG_ONES;
         end
      end
   end

endmodule
